// File: rtl/sysarr_seq_ctrl_if.sv
// Command/status and buffer-port bundle between the tile sequencer and its surroundings.
// The sequencer takes the slave side; the tile issuer and buffer models take the master side.
interface sysarr_seq_ctrl_if #(
  parameter int unsigned ROWS_NUM   = 4,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] num_vecs;
  logic [ADDR_WIDTH-1:0] wbuf_base;
  logic [ADDR_WIDTH-1:0] ibuf_base;
  logic [ADDR_WIDTH-1:0] obuf_base;
  logic                  busy;
  logic                  done;
  logic                  wbuf_rden;
  logic [ADDR_WIDTH-1:0] wbuf_addr;
  logic [ROWS_NUM-1:0]   weight_wren;
  logic                  ibuf_rden;
  logic [ADDR_WIDTH-1:0] ibuf_addr;
  logic                  active;
  logic                  obuf_wren;
  logic [ADDR_WIDTH-1:0] obuf_addr;

  modport master (
    output start, num_vecs, wbuf_base, ibuf_base, obuf_base,
    input  busy, done, wbuf_rden, wbuf_addr, weight_wren,
    input  ibuf_rden, ibuf_addr, active, obuf_wren, obuf_addr
  );

  modport slave (
    input  start, num_vecs, wbuf_base, ibuf_base, obuf_base,
    output busy, done, wbuf_rden, wbuf_addr, weight_wren,
    output ibuf_rden, ibuf_addr, active, obuf_wren, obuf_addr
  );
endinterface

// File: rtl/sysarr_seq_ctrl.sv
// Weight-stationary systolic array tile sequencer: loads weights, streams input
// vectors, and writes result rows once they emerge from the array pipeline.
module sysarr_seq_ctrl #(
  parameter int unsigned ROWS_NUM   = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ARR_LAT    = 2 * ROWS_NUM
) (
  input  logic             i_clk,
  input  logic             i_reset,
  sysarr_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_num_vecs;
  logic [ADDR_WIDTH-1:0] r_ibuf_base;
  logic [ADDR_WIDTH-1:0] r_obuf_base;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wbuf_rden;
  logic [ADDR_WIDTH-1:0] r_wbuf_addr;
  logic [ROWS_NUM-1:0]   r_weight_wren;
  logic                  r_ibuf_rden;
  logic [ADDR_WIDTH-1:0] r_ibuf_addr;
  logic                  r_active;
  logic [ARR_LAT-1:0]    r_act_sr;
  logic [ADDR_WIDTH-1:0] r_obuf_addr;

  // Nothing remains in flight once the input read and every pipeline stage
  // except the one currently presenting obuf_wren are empty.
  logic w_pipe_empty;
  assign w_pipe_empty = !r_ibuf_rden && !r_active && (r_act_sr[ARR_LAT-2:0] == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_num_vecs    <= '0;
      r_ibuf_base   <= '0;
      r_obuf_base   <= '0;
      r_wr_cnt      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wbuf_rden   <= 1'b0;
      r_wbuf_addr   <= '0;
      r_weight_wren <= '0;
      r_ibuf_rden   <= 1'b0;
      r_ibuf_addr   <= '0;
      r_active      <= 1'b0;
      r_act_sr      <= '0;
      r_obuf_addr   <= '0;
    end else begin
      // One-cycle buffer read latency, then the array latency for results.
      r_weight_wren <= {ROWS_NUM{r_wbuf_rden}};
      r_active      <= r_ibuf_rden;
      r_act_sr      <= {r_act_sr[ARR_LAT-2:0], r_active};
      if (r_act_sr[ARR_LAT-2]) begin
        r_obuf_addr <= r_obuf_base + r_wr_cnt;
        r_wr_cnt    <= r_wr_cnt + ADDR_WIDTH'(1);
      end else begin
        r_obuf_addr <= '0;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state     <= S_LOAD_W;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_wr_cnt    <= '0;
            r_num_vecs  <= bus.num_vecs;
            r_ibuf_base <= bus.ibuf_base;
            r_obuf_base <= bus.obuf_base;
            r_wbuf_rden <= 1'b1;
            r_wbuf_addr <= bus.wbuf_base + ADDR_WIDTH'(ROWS_NUM - 1);
          end
        end
        S_LOAD_W: begin
          // Bottom-row weights are fetched first since they shift furthest.
          if (r_cnt == ADDR_WIDTH'(ROWS_NUM - 1)) begin
            r_wbuf_rden <= 1'b0;
            r_wbuf_addr <= '0;
            r_cnt       <= '0;
            if (r_num_vecs != '0) begin
              r_state     <= S_STREAM;
              r_ibuf_rden <= 1'b1;
              r_ibuf_addr <= r_ibuf_base;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_cnt       <= r_cnt + ADDR_WIDTH'(1);
            r_wbuf_addr <= r_wbuf_addr - ADDR_WIDTH'(1);
          end
        end
        S_STREAM: begin
          if (r_cnt == r_num_vecs - ADDR_WIDTH'(1)) begin
            r_state     <= S_DRAIN;
            r_ibuf_rden <= 1'b0;
            r_ibuf_addr <= '0;
          end else begin
            r_cnt       <= r_cnt + ADDR_WIDTH'(1);
            r_ibuf_addr <= r_ibuf_base + r_cnt + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.wbuf_rden   = r_wbuf_rden;
  assign bus.wbuf_addr   = r_wbuf_addr;
  assign bus.weight_wren = r_weight_wren;
  assign bus.ibuf_rden   = r_ibuf_rden;
  assign bus.ibuf_addr   = r_ibuf_addr;
  assign bus.active      = r_active;
  assign bus.obuf_wren   = r_act_sr[ARR_LAT-1];
  assign bus.obuf_addr   = r_obuf_addr;

endmodule

// File: tb/tb_sysarr_seq_ctrl.sv
// Directed bench for sysarr_seq_ctrl: every output is compared each cycle against
// the tile timeline derived from start edge 0, R rows, N vectors and latency L.
module tb_sysarr_seq_ctrl;

  localparam int R = 4;
  localparam int L = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  sysarr_seq_ctrl_if #(.ROWS_NUM(4), .ADDR_WIDTH(8)) bus ();

  sysarr_seq_ctrl #(.ROWS_NUM(4), .ADDR_WIDTH(8), .ARR_LAT(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // Expected outputs in cycle c of a tile started at edge 0; en=0 expects all zeros.
  task automatic check_cycle(input int c, input bit en, input int n,
                             input int wb, input int ib, input int ob);
    logic [7:0] e_wrd, e_wad, e_wwr, e_ird, e_iad, e_act, e_owr, e_oad, e_done, e_busy;
    e_wrd  = 8'(en && c >= 1 && c <= R);
    e_wad  = (e_wrd != 0) ? 8'(wb + R - c) : 8'h00;
    e_wwr  = (en && c >= 2 && c <= R + 1) ? 8'h0F : 8'h00;
    e_ird  = 8'(en && c >= R + 1 && c <= R + n);
    e_iad  = (e_ird != 0) ? 8'(ib + c - R - 1) : 8'h00;
    e_act  = 8'(en && c >= R + 2 && c <= R + n + 1);
    e_owr  = 8'(en && c >= R + 2 + L && c <= R + n + 1 + L);
    e_oad  = (e_owr != 0) ? 8'(ob + c - R - 2 - L) : 8'h00;
    e_done = 8'(en && c == ((n == 0) ? R + 2 : R + n + 2 + L));
    e_busy = 8'(en && c >= 1 && c <= ((n == 0) ? R + 1 : R + n + 1 + L));
    chk("wbuf_rden",   c, 8'(bus.wbuf_rden),   e_wrd);
    chk("wbuf_addr",   c, bus.wbuf_addr,       e_wad);
    chk("weight_wren", c, 8'(bus.weight_wren), e_wwr);
    chk("ibuf_rden",   c, 8'(bus.ibuf_rden),   e_ird);
    chk("ibuf_addr",   c, bus.ibuf_addr,       e_iad);
    chk("active",      c, 8'(bus.active),      e_act);
    chk("obuf_wren",   c, 8'(bus.obuf_wren),   e_owr);
    chk("obuf_addr",   c, bus.obuf_addr,       e_oad);
    chk("done",        c, 8'(bus.done),        e_done);
    chk("busy",        c, 8'(bus.busy),        e_busy);
  endtask

  // Pulses start in the current cycle, then checks every cycle through one past done.
  // With spurious=1, extra start pulses are driven on cycles 3, 10 and the done cycle.
  task automatic run_tile(input int n, input int wb, input int ib, input int ob, input bit spurious);
    int last;
    last = (n == 0) ? R + 2 : R + n + 2 + L;
    bus.num_vecs  = 8'(n);
    bus.wbuf_base = 8'(wb);
    bus.ibuf_base = 8'(ib);
    bus.obuf_base = 8'(ob);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.num_vecs  = 8'h99;
    bus.wbuf_base = 8'h99;
    bus.ibuf_base = 8'h99;
    bus.obuf_base = 8'h99;
    for (int c = 1; c <= last + 1; c++) begin
      check_cycle(c, 1'b1, n, wb, ib, ob);
      if (c <= last) begin
        bus.start = spurious && (c == 3 || c == 10 || c == last);
        tick();
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.num_vecs  = 8'h00;
    bus.wbuf_base = 8'h00;
    bus.ibuf_base = 8'h00;
    bus.obuf_base = 8'h00;

    // Reset for three cycles, then idle with start low
    repeat (3) tick();
    reset = 1'b0;
    check_cycle(0, 1'b0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_cycle(i, 1'b0, 0, 0, 0, 0);
    end

    // Nominal tile
    run_tile(3, 8'h10, 8'h20, 8'h40, 1'b0);

    // Zero-vector tile: weight traffic only
    run_tile(0, 8'h30, 8'h20, 8'h40, 1'b0);

    // Address wrap-around
    run_tile(4, 8'h10, 8'hFE, 8'hFF, 1'b0);

    // Starts on cycles 3, 10 and the done cycle are ignored; next start at cycle 18 is accepted
    run_tile(3, 8'h10, 8'h20, 8'h40, 1'b1);
    run_tile(3, 8'h50, 8'h60, 8'h70, 1'b0);

    // Reset at cycle 9 of a nominal tile flushes all pending traffic
    bus.num_vecs  = 8'd3;
    bus.wbuf_base = 8'h10;
    bus.ibuf_base = 8'h20;
    bus.obuf_base = 8'h40;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check_cycle(c, 1'b1, 3, 8'h10, 8'h20, 8'h40);
      if (c == 9) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    for (int c = 10; c <= 25; c++) begin
      check_cycle(c, 1'b0, 0, 0, 0, 0);
      tick();
    end

    // A fresh start reproduces the nominal timeline
    run_tile(3, 8'h10, 8'h20, 8'h40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sysarr_seq_ctrl.md
# sysarr_seq_ctrl

Tile sequencer for the weight-stationary systolic array. On a `start` pulse it reads `rows_num` weight words from the weight buffer and loads them into the array, then streams `num_vecs` input vectors from the input buffer, and finally writes each result row to the output buffer. It sits between the buffer SRAMs and the array; input skew and result de-skew are handled by separate skew blocks.

## Interface
- `rows_num`, 4: array dimension; width of `weight_wren`.
- `addr_width`, 8: width of every buffer address and of `num_vecs`.
- `arr_lat`, 8 (2*`rows_num`): cycles from `active` asserted for a vector to that vector's result at the array `mac_out`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a tile when idle.
- `num_vecs` in `addr_width`: vectors in the tile; 0 is legal.
- `wbuf_base`, `ibuf_base`, `obuf_base` in `addr_width`: tile base addresses.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle pulse after the last result write.
- `wbuf_rden` out 1, `wbuf_addr` out `addr_width`: weight buffer read port.
- `weight_wren` out `rows_num`: per-column weight write enable to the array.
- `ibuf_rden` out 1, `ibuf_addr` out `addr_width`: input buffer read port.
- `active` out 1: array activation into row 0.
- `obuf_wren` out 1, `obuf_addr` out `addr_width`: output buffer write port.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE → LOAD_W when `start`=1. Sample `num_vecs` and the three bases on that edge and hold them for the whole tile.
- `start` is ignored in every state except IDLE.
- LOAD_W lasts `rows_num` cycles.
  - `wbuf_rden`=1 every cycle.
  - `wbuf_addr` = `wbuf_base`+`rows_num`-1 down to `wbuf_base` (bottom-row weights first), because weights shift down one row per cycle.
- LOAD_W → STREAM if `num_vecs`≠0, else → DRAIN.
- STREAM lasts `num_vecs` cycles.
  - `ibuf_rden`=1 every cycle.
  - `ibuf_addr` = `ibuf_base`+k for k = 0..`num_vecs`-1.
- STREAM → DRAIN after the last read.
- DRAIN holds until the last scheduled `obuf_wren` has been issued.
- DRAIN → DONE → IDLE. DONE lasts exactly one cycle.
- Buffer read latency is 1 cycle:
  - `weight_wren` = all ones exactly 1 cycle after each `wbuf_rden`, otherwise all zeros.
  - `active` = `ibuf_rden` delayed 1 cycle.
- `obuf_wren` = `active` delayed by `arr_lat` cycles, using a shift register so vectors stay pipelined.
- `obuf_addr` = `obuf_base`+j for the j-th write.
- Address arithmetic is modulo 2^`addr_width`; base+offset wraps silently.
- `busy`=1 in LOAD_W, STREAM and DRAIN. `busy`=0 in IDLE and DONE.
- `reset` (any state, including mid-tile):
  - Next edge goes to IDLE.
  - All delay pipelines are cleared, so no stale `weight_wren`, `active` or `obuf_wren` appears afterwards.
  - All outputs go to 0.

## Timing
- Reset value of every output is 0.
- Addresses read 0 whenever their enable is low.
- Timeline, with `start` sampled at edge 0, R=`rows_num`, N=`num_vecs`, L=`arr_lat`:
  - `wbuf_rden`: cycles 1..R.
  - `weight_wren`: cycles 2..R+1.
  - `ibuf_rden`: cycles R+1..R+N.
  - `active`: cycles R+2..R+N+1.
  - `obuf_wren`: cycles R+2+L..R+N+1+L.
  - `done`: cycle R+N+2+L.
  - `busy`: cycles 1..R+N+1+L.
- N=0:
  - No `ibuf_rden`, `active` or `obuf_wren`.
  - `busy` cycles 1..R+1.
  - `done` at cycle R+2.
- `start` asserted in the same cycle as `done` is ignored, because the controller is in DONE, not IDLE.
- Earliest accepted next `start` is the cycle after `done`.
- Back-to-back tiles therefore have at least a 1-cycle IDLE gap.
- Latency from `start` to `done` is R+N+2+L cycles.

## Test plan
- Reset check: hold `reset` 3 cycles, then release → every output is 0. With `start` held low for 20 cycles, the block stays idle with all outputs 0.
- Nominal tile (R=4, L=8, N=3, wbuf_base=0x10, ibuf_base=0x20, obuf_base=0x40), `start` at cycle 0:
  - `wbuf_addr` 0x13, 0x12, 0x11, 0x10 on cycles 1–4.
  - `weight_wren`=4'b1111 on cycles 2–5.
  - `ibuf_addr` 0x20–0x22 on cycles 5–7.
  - `active` on cycles 6–8.
  - `obuf_addr` 0x40–0x42 on cycles 14–16.
  - `done` on cycle 17.
  - `busy` high on cycles 1–16.
- N=0 tile → only weight traffic appears; `done` on cycle 6; no `active` or `obuf_wren` ever asserted.
- Wrap-around: ibuf_base=0xFE, obuf_base=0xFF, N=4 → `ibuf_addr` FE, FF, 00, 01 and `obuf_addr` FF, 00, 01, 02.
- `start` pulsed on cycles 3, 10 and 17 (the `done` cycle) → ignored; the next tile begins only from a `start` at cycle 18.
- `reset` asserted at cycle 9 of the nominal tile → from cycle 10 all outputs are 0, including pending `obuf_wren`. A fresh `start` then reproduces the nominal timeline exactly.
